shift_sequencer: RTL and testbench

//  Multi-pass controller for the 32-bit lane-sliced barrel shifter datapath. Accepts one shift
//  job (data, total amount, direction, shift/rotate) over valid/ready. Splits the amount into

---
 rtl/shift_sequencer.sv | 101 ++++++++++
 tb/tb_shift_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-pass barrel-shift controller: splits one shift job into passes of at most MAX_STEP,
// drives an external combinational shifter once per clock and returns the final word.
module shift_sequencer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHIFT_W = 2,
    parameter int unsigned AMT_W   = 5
) (
    input  logic               shift_sequencer_port_clk,
    input  logic               shift_sequencer_port_reset_n,
    input  logic               shift_sequencer_port_clear,
    input  logic               shift_sequencer_port_in_valid,
    output logic               shift_sequencer_port_in_ready,
    input  logic [WIDTH-1:0]   shift_sequencer_port_in_data,
    input  logic [AMT_W-1:0]   shift_sequencer_port_in_amt,
    input  logic               shift_sequencer_port_in_dir,
    input  logic               shift_sequencer_port_in_sr,
    output logic               shift_sequencer_port_out_valid,
    input  logic               shift_sequencer_port_out_ready,
    output logic [WIDTH-1:0]   shift_sequencer_port_out_data,
    output logic [WIDTH-1:0]   shift_sequencer_port_sh_operand,
    output logic [SHIFT_W-1:0] shift_sequencer_port_sh_shift,
    output logic               shift_sequencer_port_sh_dir,
    output logic               shift_sequencer_port_sh_sr,
    input  logic [WIDTH-1:0]   shift_sequencer_port_sh_result,
    output logic               shift_sequencer_port_busy,
    output logic [AMT_W-1:0]   shift_sequencer_port_pass_cnt
);

    localparam logic [SHIFT_W-1:0] MaxStep    = '1;
    localparam logic [AMT_W-1:0]   MaxStepAmt = AMT_W'(MaxStep);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [AMT_W-1:0]   rem_q;
    logic [AMT_W-1:0]   pass_cnt_q;
    logic               dir_q;
    logic               sr_q;
    logic [SHIFT_W-1:0] step;

    // Amount for this pass; forced to zero outside RUN so the shifter idles.
    always_comb begin
        step = '0;
        if (state_q == StRun) begin
            step = (rem_q > MaxStepAmt) ? MaxStep : rem_q[SHIFT_W-1:0];
        end
    end

    always_ff @(posedge shift_sequencer_port_clk or negedge shift_sequencer_port_reset_n) begin
        if (!shift_sequencer_port_reset_n) begin
            state_q    <= StIdle;
            data_q     <= '0;
            rem_q      <= '0;
            pass_cnt_q <= '0;
            dir_q      <= 1'b0;
            sr_q       <= 1'b0;
        end else if (shift_sequencer_port_clear) begin
            state_q <= StIdle;
            rem_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (shift_sequencer_port_in_valid) begin
                        data_q     <= shift_sequencer_port_in_data;
                        rem_q      <= shift_sequencer_port_in_amt;
                        dir_q      <= shift_sequencer_port_in_dir;
                        sr_q       <= shift_sequencer_port_in_sr;
                        pass_cnt_q <= '0;
                        state_q    <= (shift_sequencer_port_in_amt != '0) ? StRun : StDone;
                    end
                end
                StRun: begin
                    data_q     <= shift_sequencer_port_sh_result;
                    rem_q      <= rem_q - AMT_W'(step);
                    pass_cnt_q <= pass_cnt_q + 1'b1;
                    if (rem_q <= MaxStepAmt) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (shift_sequencer_port_out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign shift_sequencer_port_in_ready   = (state_q == StIdle);
    assign shift_sequencer_port_out_valid  = (state_q == StDone);
    assign shift_sequencer_port_out_data   = data_q;
    assign shift_sequencer_port_sh_operand = data_q;
    assign shift_sequencer_port_sh_shift   = step;
    assign shift_sequencer_port_sh_dir     = dir_q;
    assign shift_sequencer_port_sh_sr      = sr_q;
    assign shift_sequencer_port_busy       = (state_q != StIdle);
    assign shift_sequencer_port_pass_cnt   = pass_cnt_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the 32-bit shifter, runs a vector table, random jobs and
// hand-written backpressure / clear / async-reset sequences against a result scoreboard.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic        in_dir;
    logic        in_sr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] sh_operand;
    logic [1:0]  sh_shift;
    logic        sh_dir;
    logic        sh_sr;
    logic [31:0] sh_result;
    logic        busy;
    logic [4:0]  pass_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          passes;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] d;
        logic [4:0]  a;
        logic        dir;
        logic        sr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[7];

    shift_sequencer #(.WIDTH(32), .SHIFT_W(2), .AMT_W(5)) dut (
        .shift_sequencer_port_clk       (clk),
        .shift_sequencer_port_reset_n   (rst_n),
        .shift_sequencer_port_clear     (clear),
        .shift_sequencer_port_in_valid  (in_valid),
        .shift_sequencer_port_in_ready  (in_ready),
        .shift_sequencer_port_in_data   (in_data),
        .shift_sequencer_port_in_amt    (in_amt),
        .shift_sequencer_port_in_dir    (in_dir),
        .shift_sequencer_port_in_sr     (in_sr),
        .shift_sequencer_port_out_valid (out_valid),
        .shift_sequencer_port_out_ready (out_ready),
        .shift_sequencer_port_out_data  (out_data),
        .shift_sequencer_port_sh_operand(sh_operand),
        .shift_sequencer_port_sh_shift  (sh_shift),
        .shift_sequencer_port_sh_dir    (sh_dir),
        .shift_sequencer_port_sh_sr     (sh_sr),
        .shift_sequencer_port_sh_result (sh_result),
        .shift_sequencer_port_busy      (busy),
        .shift_sequencer_port_pass_cnt  (pass_cnt)
    );

    always #5 clk = ~clk;

    // dir=1 left, sr=1 rotate, sr=0 logical zero-fill
    function automatic logic [31:0] shf(input logic [31:0] x, input int n, input logic dir,
                                        input logic sr);
        logic [63:0] w;
        if (dir) begin
            w = {x, x} << n;
            return sr ? w[63:32] : (x << n);
        end
        w = {x, x} >> n;
        return sr ? w[31:0] : (x >> n);
    endfunction

    always_comb sh_result = shf(sh_operand, int'(sh_shift), sh_dir, sh_sr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_job(input logic [31:0] d, input logic [4:0] a, input logic dir,
                              input logic sr);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_dir   = dir;
        in_sr    = sr;
        tick();
        in_valid = 1'b0;
    endtask

    // Full job: accept, log per-pass amounts, check latency/result/count, then hand-shake out.
    task automatic run_job(input logic [31:0] d, input logic [4:0] a, input logic dir,
                           input logic sr, input logic [31:0] exp_d);
        int     cyc;
        int     rem;
        int     exp_p;
        int     exp_sh[$];
        int     got_sh[$];
        exp_t   e;
        accept_job(d, a, dir, sr);
        exp_p = (int'(a) + 2) / 3;
        rem   = int'(a);
        while (rem > 0) begin
            exp_sh.push_back(rem > 3 ? 3 : rem);
            rem -= (rem > 3 ? 3 : rem);
        end
        sb.push_back('{data: exp_d, passes: exp_p});
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            got_sh.push_back(int'(sh_shift));
            tick();
            cyc++;
        end
        // Edges after the accept edge until out_valid: one per pass.
        chk("latency", cyc, exp_p);
        chk("sh_shift_done", {30'd0, sh_shift}, 32'd0);
        chk("pass_seq_len", got_sh.size(), exp_sh.size());
        for (int i = 0; i < exp_sh.size() && i < got_sh.size(); i++) begin
            chk("sh_shift_step", got_sh[i], exp_sh[i]);
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("pass_cnt", {27'd0, pass_cnt}, e.passes);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("out_valid_after", {31'd0, out_valid}, 32'd0);
        chk("pass_cnt_hold", {27'd0, pass_cnt}, exp_p);
    endtask

    initial begin
        logic [31:0] rd;
        logic [4:0]  ra;
        logic        rdir;
        logic        rsr;
        int          cyc;
        logic        saw_valid;

        vecs[0] = '{d: 32'h12345678, a: 5'd7,  dir: 1'b1, sr: 1'b1, exp: 32'h1A2B3C09};
        vecs[1] = '{d: 32'hF000000F, a: 5'd4,  dir: 1'b0, sr: 1'b0, exp: 32'h0F000000};
        vecs[2] = '{d: 32'hDEADBEEF, a: 5'd0,  dir: 1'b1, sr: 1'b0, exp: 32'hDEADBEEF};
        vecs[3] = '{d: 32'h80000001, a: 5'd3,  dir: 1'b0, sr: 1'b1, exp: 32'h30000000};
        vecs[4] = '{d: 32'h00000001, a: 5'd31, dir: 1'b1, sr: 1'b0, exp: 32'h80000000};
        vecs[5] = '{d: 32'h12345678, a: 5'd1,  dir: 1'b0, sr: 1'b1, exp: 32'h091A2B3C};
        vecs[6] = '{d: 32'h80000000, a: 5'd6,  dir: 1'b1, sr: 1'b0, exp: 32'h00000000};

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_amt = '0; in_dir = 1'b0; in_sr = 1'b0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_sh_shift", {30'd0, sh_shift}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pass_cnt", {27'd0, pass_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_job(vecs[i].d, vecs[i].a, vecs[i].dir, vecs[i].sr, vecs[i].exp);

        for (int i = 0; i < 6; i++) begin
            rd   = $urandom;
            ra   = 5'($urandom_range(0, 31));
            rdir = 1'($urandom_range(0, 1));
            rsr  = 1'($urandom_range(0, 1));
            run_job(rd, ra, rdir, rsr, shf(rd, int'(ra), rdir, rsr));
        end

        // Backpressure: result held 5 cycles while a new job is offered.
        accept_job(32'h000000FF, 5'd2, 1'b1, 1'b0);
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("bp_latency", cyc, 1);
        in_valid = 1'b1;
        in_data  = 32'h55555555;
        in_amt   = 5'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data", out_data, 32'h000003FC);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_idle", {31'd0, in_ready}, 32'd1);
        chk("bp_pass_cnt", {27'd0, pass_cnt}, 32'd1);

        // Clear after the fourth pass of a 31-step job.
        accept_job(32'hA5A5A5A5, 5'd31, 1'b1, 1'b0);
        repeat (4) tick();
        chk("clr_pre_pass_cnt", {27'd0, pass_cnt}, 32'd4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
        chk("clr_pass_cnt", {27'd0, pass_cnt}, 32'd4);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            saw_valid |= out_valid;
            tick();
        end
        chk("clr_no_out_valid", {31'd0, saw_valid}, 32'd0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h11111111;
        in_amt   = 5'd5;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_wins_busy", {31'd0, busy}, 32'd0);
        chk("clr_wins_pass_cnt", {27'd0, pass_cnt}, 32'd4);
        run_job(32'h0000F00F, 5'd8, 1'b0, 1'b1, shf(32'h0000F00F, 8, 1'b0, 1'b1));

        // Asynchronous reset in the middle of RUN.
        accept_job(32'hCAFEF00D, 5'd31, 1'b1, 1'b1);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_sh_shift", {30'd0, sh_shift}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_pass_cnt", {27'd0, pass_cnt}, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        run_job(32'hCAFEF00D, 5'd31, 1'b1, 1'b1, shf(32'hCAFEF00D, 31, 1'b1, 1'b1));

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
